add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 37 +++
 rtl/addsub_core.sv | 38 +++
 rtl/add_arbiter.sv | 119 +++++++++++
 tb/tb_add_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types and encodings for the two-requester arithmetic arbiter.
package add_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    // One-hot select bit positions inside sel[SEL_W-1:0]
    localparam int SEL_ADD = 0;
    localparam int SEL_SUB = 1;
    localparam int SEL_INC = 2;
    localparam int SEL_DEC = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    // Opcode value doubles as the one-hot bit index
    function automatic logic [SEL_W-1:0] op_to_sel(input logic [1:0] op);
        op_to_sel = SEL_W'(1) << op;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/sub/inc/dec built around one shared 8-bit adder.
module addsub_core
    import add_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              cin;

    // Steer operands into the adder; all-zero sel yields 0 + 0 + 0
    always_comb begin
        opa = '0;
        opb = '0;
        cin = 1'b0;
        if (sel[SEL_ADD]) begin
            opa = a;
            opb = b;
        end else if (sel[SEL_SUB]) begin
            opa = a;
            opb = ~b;
            cin = 1'b1;
        end else if (sel[SEL_INC]) begin
            opa = a;
            cin = 1'b1;
        end else if (sel[SEL_DEC]) begin
            opa = a;
            opb = '1;
        end
    end

    assign y = opa + opb + {{(DATA_W-1){1'b0}}, cin};

endmodule

// File: rtl/add_arbiter.sv
// Two-requester arbiter feeding a shared add/sub unit: IDLE -> EXEC -> HOLD.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    state_e            state, state_nxt;
    logic              last_grant;
    logic              grant_id;
    logic              accept;
    req_t              req_sel;
    logic [SEL_W-1:0]  cap_sel;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              cap_id;
    logic [DATA_W-1:0] core_y;

    // Pick the winner: single valid wins, ties go by rotation or to req0
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = RR_EN ? ~last_grant : 1'b0;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    // Operand mux for the granted requester
    always_comb begin
        req_sel = grant_id ? '{op: req1_op, a: req1_a, b: req1_b}
                           : '{op: req0_op, a: req0_a, b: req0_b};
    end

    // Next state; ready is only ever offered from IDLE and never during reset
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;
    assign res_valid  = (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);

    // State register; last_grant resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept)
                last_grant <= grant_id;
        end
    end

    // Capture the granted operation, opcode decoded to one-hot here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_sel <= '0;
            cap_a   <= '0;
            cap_b   <= '0;
            cap_id  <= 1'b0;
        end else if (accept) begin
            cap_sel <= op_to_sel(req_sel.op);
            cap_a   <= req_sel.a;
            cap_b   <= req_sel.b;
            cap_id  <= grant_id;
        end
    end

    addsub_core u_core (
        .a   (cap_a),
        .b   (cap_b),
        .sel (cap_sel),
        .y   (core_y)
    );

    // Result register, loaded once in EXEC and held through HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_id   <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_data <= core_y;
            res_id   <= cap_id;
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized self-checking bench; round-robin and fixed-priority instances share inputs.
module tb_add_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       res_ready = 1'b0;

    logic       req0_ready, req1_ready, res_valid, res_id, busy;
    logic [7:0] res_data;
    logic       f_req0_ready, f_req1_ready, f_res_valid, f_res_id, f_busy;
    logic [7:0] f_res_data;

    int   checks = 0;
    int   errors = 0;
    logic m_last;

    // Observations returned by run_txn
    logic [1:0] o_rdy, o_rdy_f;
    logic       o_v_early, o_v_late, o_id, o_f_id, o_hold_ok, o_v_after;
    logic [7:0] o_d, o_f_d;

    always #5 clk = ~clk;

    add_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    add_arbiter #(.RR_EN(1'b0)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(f_res_valid), .res_ready(res_ready), .res_id(f_res_id), .res_data(f_res_data), .busy(f_busy)
    );

    // Reference arithmetic, modulo 256
    function automatic logic [7:0] ref_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 256;
            2'd2:    r = int'(a) + 1;
            default: r = int'(a) + 255;
        endcase
        r = r % 256;
        return r[7:0];
    endfunction

    // Reference round-robin grant: lone requester wins, ties go to the one not granted last
    function automatic logic ref_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
    endtask

    // Drive one request round; granted requester drops valid after capture, loser holds
    task automatic run_txn(input logic v0, input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic v1, input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                           input int stall);
        @(negedge clk);
        res_ready  = 1'b0;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        o_rdy   = {req1_ready, req0_ready};
        o_rdy_f = {f_req1_ready, f_req0_ready};
        @(posedge clk); #1;
        o_v_early = res_valid;
        if (o_rdy[0]) req0_valid = 1'b0;
        if (o_rdy[1]) req1_valid = 1'b0;
        @(posedge clk); #1;
        o_v_late = res_valid;
        o_d      = res_data;
        o_id     = res_id;
        o_f_d    = f_res_data;
        o_f_id   = f_res_id;
        o_hold_ok = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== o_d || res_id !== o_id ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                o_hold_ok = 1'b0;
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        o_v_after = res_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req1_ready, req0_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got %b exp 0", res_id); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got %h exp 00", res_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (f_req0_ready !== 1'b0 || f_req1_ready !== 1'b0 || f_res_valid !== 1'b0 || f_busy !== 1'b0)
            begin errors++; $display("FAIL reset_fixed got rdy %b%b v %b busy %b exp 0", f_req1_ready, f_req0_ready, f_res_valid, f_busy); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
    endtask

    task automatic test_single_add();
        run_txn(1'b1, 2'd0, 8'h3C, 8'h05, 1'b0, 2'd0, 8'h00, 8'h00, 0);
        checks++; if (o_rdy !== 2'b01) begin errors++; $display("FAIL add_ready got %b exp 01", o_rdy); end
        checks++; if (o_v_early !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", o_v_early); end
        checks++; if (o_v_late !== 1'b1) begin errors++; $display("FAIL add_latency got %b exp 1", o_v_late); end
        checks++; if (o_d !== 8'h41) begin errors++; $display("FAIL add_data got %h exp 41", o_d); end
        checks++; if (o_id !== 1'b0) begin errors++; $display("FAIL add_id got %b exp 0", o_id); end
        checks++; if (o_v_after !== 1'b0) begin errors++; $display("FAIL add_valid_drop got %b exp 0", o_v_after); end
        m_last = 1'b0;
    endtask

    task automatic test_wrap();
        logic [1:0] ops [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] as  [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] bs  [4] = '{8'h01, 8'h5A, 8'hA5, 8'h02};
        logic [7:0] exp [4] = '{8'hFF, 8'h00, 8'hFF, 8'h01};
        for (int i = 0; i < 4; i++) begin
            // alternate which requester carries the op, only one valid at a time
            if (i % 2 == 0) run_txn(1'b1, ops[i], as[i], bs[i], 1'b0, 2'd0, 8'h00, 8'h00, 1);
            else            run_txn(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, ops[i], as[i], bs[i], 1);
            checks++; if (o_d !== exp[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, o_d, exp[i]); end
            checks++; if (o_id !== 1'(i % 2)) begin errors++; $display("FAIL wrap_id[%0d] got %b exp %0d", i, o_id, i % 2); end
            m_last = 1'(i % 2);
        end
    endtask

    task automatic test_rr_tie();
        logic [1:0] op0, op1;
        logic [7:0] a0, b0, a1, b1;
        logic       g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op0 = 2'($urandom_range(0, 3)); a0 = 8'($urandom); b0 = 8'($urandom);
            op1 = 2'($urandom_range(0, 3)); a1 = 8'($urandom); b1 = 8'($urandom);
            g = 1'(i % 2);
            run_txn(1'b1, op0, a0, b0, 1'b1, op1, a1, b1, 0);
            checks++; if (o_rdy !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant[%0d] got %b exp id %0d", i, o_rdy, g); end
            checks++; if (o_id !== g) begin errors++; $display("FAIL rr_id[%0d] got %b exp %b", i, o_id, g); end
            checks++; if (o_d !== (g ? ref_calc(op1, a1, b1) : ref_calc(op0, a0, b0)))
                begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, o_d, g ? ref_calc(op1, a1, b1) : ref_calc(op0, a0, b0)); end
            // the fixed-priority instance sees the same tie and must starve req1
            checks++; if (o_rdy_f !== 2'b01) begin errors++; $display("FAIL fix_grant[%0d] got %b exp 01", i, o_rdy_f); end
            checks++; if (o_f_id !== 1'b0 || o_f_d !== ref_calc(op0, a0, b0))
                begin errors++; $display("FAIL fix_result[%0d] got id %b data %h exp id 0 data %h", i, o_f_id, o_f_d, ref_calc(op0, a0, b0)); end
            m_last = g;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_txn(1'b1, 2'd0, 8'h10, 8'h20, 1'b1, 2'd1, 8'h50, 8'h08, 5);
        checks++; if (o_rdy !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", o_rdy); end
        checks++; if (o_d !== 8'h30 || o_v_late !== 1'b1) begin errors++; $display("FAIL bp_result got v %b data %h exp v 1 data 30", o_v_late, o_d); end
        checks++; if (o_hold_ok !== 1'b1) begin errors++; $display("FAIL bp_hold got %b exp 1", o_hold_ok); end
        checks++; if (o_v_after !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", o_v_after); end
        m_last = 1'b0;
        run_txn(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'd1, 8'h50, 8'h08, 0);
        checks++; if (o_rdy !== 2'b10) begin errors++; $display("FAIL bp_req1_grant got %b exp 10", o_rdy); end
        checks++; if (o_d !== 8'h48 || o_id !== 1'b1) begin errors++; $display("FAIL bp_req1_result got id %b data %h exp id 1 data 48", o_id, o_d); end
        m_last = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic stay_ok;
        @(negedge clk);
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 8'h77; req0_b = 8'h11;
        @(posedge clk); #2;
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_exec got busy %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_id !== 1'b0 || res_data !== 8'h00 ||
                      req0_ready !== 1'b0 || req1_ready !== 1'b0)
            begin errors++; $display("FAIL mid_reset_outputs got v %b busy %b id %b data %h exp all 0", res_valid, busy, res_id, res_data); end
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
        stay_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) stay_ok = 1'b0;
        end
        checks++; if (stay_ok !== 1'b1) begin errors++; $display("FAIL mid_no_result got %b exp 1", stay_ok); end
    endtask

    task automatic test_random();
        logic       pv  [2] = '{1'b0, 1'b0};
        logic [1:0] pop [2];
        logic [7:0] pa  [2];
        logic [7:0] pb  [2];
        logic       g;
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r]) begin
                    pop[r] = 2'($urandom_range(0, 3));
                    pa[r]  = 8'($urandom);
                    pb[r]  = 8'($urandom);
                    pv[r]  = 1'($urandom_range(0, 1));
                end
            end
            if (!pv[0] && !pv[1]) pv[$urandom_range(0, 1)] = 1'b1;
            g = ref_grant(pv[0], pv[1], m_last);
            run_txn(pv[0], pop[0], pa[0], pb[0], pv[1], pop[1], pa[1], pb[1], int'($urandom_range(0, 3)));
            checks++; if (o_rdy !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_grant[%0d] got %b exp id %0d", i, o_rdy, g); end
            checks++; if (o_v_early !== 1'b0 || o_v_late !== 1'b1) begin errors++; $display("FAIL rnd_latency[%0d] got %b%b exp 01", i, o_v_early, o_v_late); end
            checks++; if (o_d !== ref_calc(pop[g], pa[g], pb[g]) || o_id !== g)
                begin errors++; $display("FAIL rnd_result[%0d] got id %b data %h exp id %b data %h", i, o_id, o_d, g, ref_calc(pop[g], pa[g], pb[g])); end
            checks++; if (o_hold_ok !== 1'b1 || o_v_after !== 1'b0) begin errors++; $display("FAIL rnd_hold[%0d] got %b%b exp 10", i, o_hold_ok, o_v_after); end
            m_last = g;
            pv[g]  = 1'b0;
            // an ungranted request may be withdrawn without affecting anything
            if (pv[~g] && $urandom_range(0, 3) == 0) pv[~g] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_wrap();
        test_rr_tie();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
